// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader and its users.
// Holds the receiver and loader state encodings, the default sync marker,
// the checksum width and the stack-core opcodes shared with the core and benches.
package uart_program_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_WAIT_SYNC,
        LD_GET_LEN,
        LD_GET_DATA,
        LD_GET_CSUM
    } ld_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CSUM_W        = 8;

    // Stack-core opcodes
    localparam logic [7:0] OP_PUSH0 = 8'h00;
    localparam logic [7:0] OP_INC   = 8'h02;
    localparam logic [7:0] OP_POP   = 8'h03;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchroniser.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rx_i              asynchronous serial line, idles high
//   byte_valid_o      1-cycle pulse, byte_data_o holds the received byte
//   byte_data_o       last received byte (LSB first on the wire)
//   frame_err_o       1-cycle pulse when the stop bit samples low
module uart_rx_byte
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 139
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q && rx_prev_q) state_d = RX_START;
            end
            RX_START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: parses frames SYNC, len, len instruction bytes, XOR
// checksum, and writes the instructions into the core's program memory.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   rx                UART receive line
//   prog_we/addr/wdata  program memory write port (1-cycle strobe)
//   prog_len          number of valid instructions
//   core_hold         stalls the core while memory may be inconsistent
//   load_done         1-cycle pulse, frame accepted
//   load_error        1-cycle pulse, frame rejected
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 139,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 1600000,
    parameter int         RESET_LEN    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        prog_wdata,
    output logic [ADDR_W:0]   prog_len,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error
);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (CLK),
        .rst_i       (RST),
        .rx_i        (rx),
        .byte_valid_o(byte_valid),
        .byte_data_o (byte_data),
        .frame_err_o (frame_err)
    );

    ld_state_e         state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        rem_q, rem_d;
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              hold_q, hold_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              fail;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= LD_WAIT_SYNC;
            len_q      <= '0;
            rem_q      <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            tmo_q      <= '0;
            prog_len_q <= (ADDR_W+1)'(RESET_LEN);
            hold_q     <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            tmo_q      <= tmo_d;
            prog_len_q <= prog_len_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        prog_len_d = prog_len_q;
        hold_d     = hold_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fail       = 1'b0;

        // tmo_q reads k in the k-th cycle after byte_valid, so the registered
        // error pulse lands exactly TIMEOUT_CLKS cycles after the last byte.
        if (byte_valid)                  tmo_d = TMO_W'(1);
        else if (state_q != LD_WAIT_SYNC) tmo_d = tmo_q + 1'b1;
        else                             tmo_d = '0;

        case (state_q)
            LD_WAIT_SYNC: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    hold_d  = 1'b1;
                    csum_d  = '0;
                    state_d = LD_GET_LEN;
                end
            end
            LD_GET_LEN: begin
                if (byte_valid) begin
                    if (byte_data == 8'd0) begin
                        fail = 1'b1;
                    end else begin
                        len_d   = byte_data;
                        rem_d   = byte_data;
                        csum_d  = byte_data;
                        addr_d  = '0;
                        state_d = LD_GET_DATA;
                    end
                end
            end
            LD_GET_DATA: begin
                // Every byte here is an instruction, including SYNC_BYTE values.
                if (byte_valid) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = byte_data;
                    csum_d  = csum_q ^ byte_data;
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = LD_GET_CSUM;
                end
            end
            LD_GET_CSUM: begin
                if (byte_valid) begin
                    if (byte_data == csum_q) begin
                        prog_len_d = (ADDR_W+1)'(len_q);
                        hold_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = LD_WAIT_SYNC;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            default: state_d = LD_WAIT_SYNC;
        endcase

        if (state_q != LD_WAIT_SYNC && (frame_err || (!byte_valid && tmo_q == TMO_LAST)))
            fail = 1'b1;

        // core_hold deliberately stays set: memory may be partly overwritten.
        if (fail) begin
            err_d   = 1'b1;
            state_d = LD_WAIT_SYNC;
        end
    end

    assign prog_we    = we_q;
    assign prog_addr  = waddr_q;
    assign prog_wdata = wdata_q;
    assign prog_len   = prog_len_q;
    assign core_hold  = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;
    import uart_program_loader_pkg::*;

    localparam int CPB    = 16;
    localparam int ADDR_W = 8;
    localparam int TMO    = 3000;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              rx  = 1'b1;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_wdata;
    logic [ADDR_W:0]   prog_len;
    logic              core_hold, load_done, load_error;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5),
        .TIMEOUT_CLKS(TMO), .RESET_LEN(4)
    ) dut (
        .CLK(CLK), .RST(RST), .rx(rx),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .prog_len(prog_len), .core_hold(core_hold),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int wr_n = 0, done_n = 0, err_n = 0, both_n = 0;
    int we_cyc = 0, err_cyc = 0;
    logic [7:0] wr_addr [64];
    logic [7:0] wr_data [64];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (prog_we && wr_n < 64) begin
                wr_addr[wr_n] = prog_addr;
                wr_data[wr_n] = prog_wdata;
                wr_n++;
                we_cyc = cyc;
            end
            if (load_done) done_n++;
            if (load_error) begin err_n++; err_cyc = cyc; end
            if (load_done && load_error) both_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
        chk({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
        chk({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge CLK);
        end
        rx = stop;
        repeat (CPB) @(posedge CLK);
        rx = 1'b1;
        repeat (4) @(posedge CLK);
    endtask

    int w0, d0, e0;

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_we",    32'(prog_we),    0);
        chk("rst_addr",  32'(prog_addr),  0);
        chk("rst_wdata", 32'(prog_wdata), 0);
        chk("rst_len",   32'(prog_len),   4);
        chk("rst_hold",  32'(core_hold),  0);
        chk("rst_done",  32'(load_done),  0);
        chk("rst_err",   32'(load_error), 0);
        RST = 1'b0;
        repeat (5) @(posedge CLK);

        // Valid frame A5 04 00 02 02 03 07
        w0 = wr_n; d0 = done_n; e0 = err_n;
        send_byte(8'hA5, 1'b1);
        chk("a_hold_mid", 32'(core_hold), 1);
        send_byte(8'h04, 1'b1);
        send_byte(OP_PUSH0, 1'b1);
        send_byte(OP_INC, 1'b1);
        send_byte(OP_INC, 1'b1);
        send_byte(OP_POP, 1'b1);
        chk("a_hold_pre", 32'(core_hold), 1);
        send_byte(8'h07, 1'b1);
        chk("a_writes", 32'(wr_n - w0), 4);
        chk_wr("a_w0", w0 + 0, 8'd0, 8'h00);
        chk_wr("a_w1", w0 + 1, 8'd1, 8'h02);
        chk_wr("a_w2", w0 + 2, 8'd2, 8'h02);
        chk_wr("a_w3", w0 + 3, 8'd3, 8'h03);
        chk("a_done", 32'(done_n - d0), 1);
        chk("a_err",  32'(err_n - e0), 0);
        chk("a_len",  32'(prog_len), 4);
        chk("a_hold", 32'(core_hold), 0);

        // Same frame, bad checksum 08
        w0 = wr_n; d0 = done_n; e0 = err_n;
        send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h08, 1'b1);
        chk("b_writes", 32'(wr_n - w0), 4);
        chk("b_err",    32'(err_n - e0), 1);
        chk("b_done",   32'(done_n - d0), 0);
        chk("b_len",    32'(prog_len), 4);
        chk("b_hold",   32'(core_hold), 1);

        // Recovery frame A5 02 02 03 csum 03 (also SYNC-valued csum path not used)
        w0 = wr_n; d0 = done_n;
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h03, 1'b1);
        chk("c_done", 32'(done_n - d0), 1);
        chk("c_len",  32'(prog_len), 2);
        chk("c_hold", 32'(core_hold), 0);
        chk_wr("c_w1", w0 + 1, 8'd1, 8'h03);

        // 55 ignored, A5 then len 0 -> error, no writes
        w0 = wr_n; d0 = done_n; e0 = err_n;
        send_byte(8'h55, 1'b1);
        chk("d_hold_55", 32'(core_hold), 0);
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
        chk("d_err",    32'(err_n - e0), 1);
        chk("d_writes", 32'(wr_n - w0), 0);
        chk("d_hold",   32'(core_hold), 1);
        chk("d_len",    32'(prog_len), 2);

        // Short low glitch (~0.3 bit) on idle line
        w0 = wr_n; d0 = done_n; e0 = err_n;
        rx = 1'b0; repeat (5) @(posedge CLK);
        rx = 1'b1; repeat (4 * CPB) @(posedge CLK);
        chk("g_evts", 32'((wr_n - w0) + (done_n - d0) + (err_n - e0)), 0);
        chk("g_len",  32'(prog_len), 2);

        // Timeout: A5 02 11 then silence
        w0 = wr_n; e0 = err_n;
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h11, 1'b1);
        for (int k = 0; k < TMO + 500 && err_n == e0; k++) @(posedge CLK);
        repeat (10) @(posedge CLK);
        chk("t_writes", 32'(wr_n - w0), 1);
        chk_wr("t_w0", w0, 8'd0, 8'h11);
        chk("t_err",  32'(err_n - e0), 1);
        // prog_we trails byte_valid by one cycle
        chk("t_gap",  32'(err_cyc - we_cyc), 32'(TMO - 1));

        // Stop bit low on data byte after A5 01
        w0 = wr_n; e0 = err_n;
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h3C, 1'b0);
        repeat (4) @(posedge CLK);
        chk("s_err",    32'(err_n - e0), 1);
        chk("s_writes", 32'(wr_n - w0), 0);

        // RST mid-frame
        send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        chk("r_hold_pre", 32'(core_hold), 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("r_hold", 32'(core_hold), 0);
        chk("r_len",  32'(prog_len), 4);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(posedge CLK);

        // Frame after reset: A5 01 03 csum 02
        w0 = wr_n; d0 = done_n;
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h02, 1'b1);
        chk("p_done", 32'(done_n - d0), 1);
        chk("p_len",  32'(prog_len), 1);
        chk_wr("p_w0", w0, 8'd0, 8'h03);
        chk("both_hi", 32'(both_n), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
